get_buffer: RTL and testbench

//  Receive-side buffer directly downstream of the stream-accept enable logic. Stores run-phase data words (get_v)
//  in a FIFO that drains to the compute cores, and loads com-phase words (get_c) into a config register file.

---
 rtl/get_buffer_pkg.sv | 21 ++
 rtl/get_buffer_if.sv | 32 +++
 rtl/get_buffer_sync_fifo.sv | 61 ++++++
 rtl/get_buffer.sv | 142 ++++++++++++++
 tb/tb_get_buffer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/get_buffer_pkg.sv
// Shared types and defaults for the receive-side get buffer.
package get_buffer_pkg;

  localparam int GB_DATA_W  = 64;
  localparam int GB_NUM_CFG = 4;

  // Meaning of each config register slot loaded during the com phase
  typedef enum logic [1:0] {
    CFG_LEN  = 2'd0,
    CFG_ADDR = 2'd1,
    CFG_MODE = 2'd2,
    CFG_RSV  = 2'd3
  } cfg_idx_e;

  // One FIFO slot: the data word plus its end-of-run tag
  typedef struct packed {
    logic                 last;
    logic [GB_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/get_buffer_if.sv
// Stream-side and core-side signals of the get buffer, bundled.
interface get_buffer_if import get_buffer_pkg::*; #(
  parameter int DATA_W  = GB_DATA_W,
  parameter int NUM_CFG = GB_NUM_CFG
);

  logic                        run;
  logic                        com;
  logic                        get_v;
  logic                        get_c;
  logic [DATA_W-1:0]           get_data;
  logic                        core_ready;
  logic                        core_valid;
  logic [DATA_W-1:0]           core_data;
  logic                        core_last;
  logic                        almost_full;
  logic                        overflow;
  logic [NUM_CFG*DATA_W-1:0]   cfg;

  // Upstream accept logic plus the cores
  modport master (
    output run, com, get_v, get_c, get_data, core_ready,
    input  core_valid, core_data, core_last, almost_full, overflow, cfg
  );

  // The buffer itself
  modport slave (
    input  run, com, get_v, get_c, get_data, core_ready,
    output core_valid, core_data, core_last, almost_full, overflow, cfg
  );

endinterface

// File: rtl/get_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO: head word is read combinationally from storage.
// Pointers carry one extra wrap bit so full/empty fall out of an MSB compare.
module sync_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [PTR_W-1:0] o_count
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PTR_W-2:0] w_wr_addr;
  logic [PTR_W-2:0] w_rd_addr;
  logic             w_rd;
  logic             w_wr;

  assign w_wr_addr = r_wr_ptr[PTR_W-2:0];
  assign w_rd_addr = r_rd_ptr[PTR_W-2:0];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (w_wr_addr == w_rd_addr);
  assign o_count = r_wr_ptr - r_rd_ptr;

  // A read on an empty FIFO is ignored; a read on a full FIFO frees the slot
  // that a same-cycle write then reuses.
  assign w_rd = i_rd_en & ~o_empty;
  assign w_wr = i_wr_en & (~o_full | w_rd);

  assign o_rd_data = r_mem[w_rd_addr];

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_wr_addr] <= i_wr_data;
    end
  end

  // Read/write pointers with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/get_buffer.sv
// Receive-side buffer: run-phase words go through a show-ahead FIFO to the
// cores with an end-of-run tag; com-phase words load a small config file.
module get_buffer import get_buffer_pkg::*; #(
  parameter int DATA_W   = GB_DATA_W,
  parameter int DEPTH    = 16,
  parameter int NUM_CFG  = GB_NUM_CFG,
  parameter int AF_SLACK = 2
) (
  input logic         clk,
  input logic         rst_n,
  get_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int ENT_W = DATA_W + 1;

  // A programmed length of zero behaves like one: every word is last
  function automatic logic [DATA_W-1:0] effective_len(input logic [DATA_W-1:0] len);
    return (len == '0) ? DATA_W'(1) : len;
  endfunction

  // Config index steps forward and wraps after the last register
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_CFG - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  logic [DATA_W-1:0] r_cfg [NUM_CFG];
  logic [IDX_W-1:0]  r_cfg_idx;
  logic [DATA_W-1:0] r_word_cnt;
  logic              r_run_d;
  logic              r_com_d;
  logic              r_overflow;

  logic              w_com_rise;
  logic              w_run_fall;
  logic              w_cfg_wr;
  logic [IDX_W-1:0]  w_idx_base;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_free;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_len_m1;
  logic              w_tag_last;
  logic [ENT_W-1:0]  w_wr_ent;
  logic [ENT_W-1:0]  w_rd_ent;

  assign w_com_rise = bus.com & ~r_com_d;
  assign w_run_fall = ~bus.run & r_run_d;

  // A run beat takes priority if both beats ever show up together
  assign w_cfg_wr   = bus.get_c & ~bus.get_v;
  assign w_idx_base = w_com_rise ? '0 : r_cfg_idx;

  assign w_rd_acc = ~w_empty & bus.core_ready;
  assign w_wr_acc = bus.get_v & (~w_full | w_rd_acc);

  assign w_len_m1   = effective_len(r_cfg[IDX_W'(CFG_LEN)]) - DATA_W'(1);
  assign w_tag_last = (r_word_cnt == w_len_m1);
  assign w_wr_ent   = {w_tag_last, bus.get_data};

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_data (w_wr_ent),
    .i_rd_en   (w_rd_acc),
    .o_rd_data (w_rd_ent),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count)
  );

  assign w_free = CNT_W'(DEPTH) - w_count;

  assign bus.core_valid  = ~w_empty;
  assign bus.core_data   = w_rd_ent[DATA_W-1:0];
  assign bus.core_last   = w_rd_ent[DATA_W] & ~w_empty;
  assign bus.almost_full = (w_free <= CNT_W'(AF_SLACK));
  assign bus.overflow    = r_overflow;

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
    assign bus.cfg[g*DATA_W +: DATA_W] = r_cfg[g];
  end

  // Phase-level history for the com rise / run fall detectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_d <= 1'b0;
      r_com_d <= 1'b0;
    end else begin
      r_run_d <= bus.run;
      r_com_d <= bus.com;
    end
  end

  // Config register file loaded one beat at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= '0;
    end else if (w_cfg_wr) begin
      r_cfg[w_idx_base] <= bus.get_data;
    end
  end

  // Config write index: restarts at 0 on each com rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_idx <= '0;
    end else if (w_cfg_wr) begin
      r_cfg_idx <= next_idx(w_idx_base);
    end else begin
      r_cfg_idx <= w_idx_base;
    end
  end

  // Run word counter: restarts after each tagged word and when run ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_run_fall) begin
      r_word_cnt <= '0;
    end else if (w_wr_acc) begin
      r_word_cnt <= w_tag_last ? '0 : r_word_cnt + DATA_W'(1);
    end
  end

  // Sticky overflow: a run beat arrived with no room and no read to make room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (bus.get_v & w_full & ~w_rd_acc) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_get_buffer.sv
// Self-checking bench for get_buffer: directed scenarios plus a randomized
// phase, all compared against a queue-based behavioural model.
module tb_get_buffer;
  import get_buffer_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int NCFG  = 4;
  localparam int AFS   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  get_buffer_if #(.DATA_W(DW), .NUM_CFG(NCFG)) bif ();

  get_buffer #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .NUM_CFG  (NCFG),
    .AF_SLACK (AFS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // Behavioural model state
  fifo_entry_t   m_q[$];
  logic [DW-1:0] m_cfg [NCFG];
  int            m_idx;
  logic [DW-1:0] m_wcnt;
  bit            m_ovf;
  bit            m_com_d;
  bit            m_run_d;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
    m_idx   = 0;
    m_wcnt  = '0;
    m_ovf   = 1'b0;
    m_com_d = 1'b0;
    m_run_d = 1'b0;
  endfunction

  // One clock of the reference behaviour, from the inputs seen at the edge
  function automatic void model_step(input bit run, input bit com, input bit v, input bit c,
                                     input bit rdy, input logic [DW-1:0] d);
    bit            full;
    bit            rd;
    logic [DW-1:0] len;
    fifo_entry_t   e;
    int            idx;
    full = (m_q.size() == DEPTH);
    rd   = (m_q.size() > 0) && rdy;
    if (rd) void'(m_q.pop_front());
    if (v) begin
      if (!full || rd) begin
        len    = (m_cfg[0] == '0) ? 64'd1 : m_cfg[0];
        e.last = (m_wcnt == len - 64'd1);
        e.data = d;
        m_q.push_back(e);
        m_wcnt = e.last ? 64'd0 : m_wcnt + 64'd1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_run_d && !run) m_wcnt = '0;
    if (c && !v) begin
      idx        = (com && !m_com_d) ? 0 : m_idx;
      m_cfg[idx] = d;
      m_idx      = (idx + 1) % NCFG;
    end else if (com && !m_com_d) begin
      m_idx = 0;
    end
    m_com_d = com;
    m_run_d = run;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, bif.core_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check({tag, ".data"}, bif.core_data, m_q[0].data);
      check({tag, ".last"}, bif.core_last, m_q[0].last);
    end
    check({tag, ".af"}, bif.almost_full, (DEPTH - m_q.size()) <= AFS);
    check({tag, ".ovf"}, bif.overflow, m_ovf);
    for (int i = 0; i < NCFG; i++)
      check($sformatf("%s.cfg%0d", tag, i), bif.cfg[i*DW +: DW], m_cfg[i]);
  endtask

  task automatic drive(input bit run, input bit com, input bit v, input bit c,
                       input bit rdy, input logic [DW-1:0] d);
    bif.run        = run;
    bif.com        = com;
    bif.get_v      = v;
    bif.get_c      = c;
    bif.core_ready = rdy;
    bif.get_data   = d;
  endtask

  // Advance one clock, update the model, then compare away from the edge
  task automatic tick(input string tag);
    bit            run, com, v, c, rdy;
    logic [DW-1:0] d;
    run = bif.run; com = bif.com; v = bif.get_v; c = bif.get_c;
    rdy = bif.core_ready; d = bif.get_data;
    @(posedge clk);
    model_step(run, com, v, c, rdy, d);
    #1;
    check_outputs(tag);
  endtask

  localparam logic [DW-1:0] T3 = 64'h3300_0000_0000_0000;
  localparam logic [DW-1:0] T4 = 64'h4400_0000_0000_0000;
  localparam logic [DW-1:0] T5 = 64'h5555_AAAA_5555_AAAA;
  localparam logic [DW-1:0] T6 = 64'h6666_0123_4567_89AB;

  initial begin
    logic [DW-1:0] cfg_vals [5];
    int            drained;
    bit            r_run, r_com, v, c, rdy;
    int            rdy_pct;
    logic [DW-1:0] d;

    cfg_vals[0] = 64'hAAAA_0000_0000_000A;
    cfg_vals[1] = 64'hBBBB_0000_0000_000B;
    cfg_vals[2] = 64'hCCCC_0000_0000_000C;
    cfg_vals[3] = 64'hDDDD_0000_0000_000D;
    cfg_vals[4] = 64'hEEEE_0000_0000_000E;

    drive(0, 0, 0, 0, 0, '0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // Config load with wrap on the fifth beat
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 0, cfg_vals[i]);
      tick("cfg");
    end
    check("cfg_wrap0", bif.cfg[0 +: DW], cfg_vals[4]);
    check("cfg_keep1", bif.cfg[DW +: DW], cfg_vals[1]);
    drive(0, 0, 0, 0, 0, '0);
    tick("cfg_idle");

    // Program run length 3 and stream 7 words with cores always ready
    drive(0, 1, 0, 1, 0, 64'd3);   tick("len");
    drive(0, 1, 0, 1, 0, 64'd100); tick("len");
    drive(0, 1, 0, 1, 0, 64'd200); tick("len");
    drive(0, 1, 0, 1, 0, 64'd300); tick("len");
    drive(0, 0, 0, 0, 0, '0);      tick("len_idle");
    for (int n = 1; n <= 7; n++) begin
      drive(1, 0, 1, 0, 1, T3 + DW'(n));
      tick("run7");
      check($sformatf("last_w%0d", n), bif.core_last, (n == 3) || (n == 6));
      check($sformatf("data_w%0d", n), bif.core_data, T3 + DW'(n));
    end
    drive(0, 0, 0, 0, 1, '0);
    tick("run7_drain");
    tick("run7_idle");

    // Fill to full with the cores stalled
    for (int n = 1; n <= 16; n++) begin
      drive(1, 0, 1, 0, 0, T4 + DW'(n));
      tick("fill");
      if (n == 13) check("af_13", bif.almost_full, 1'b0);
      if (n == 14) check("af_14", bif.almost_full, 1'b1);
    end
    check("full_no_ovf", bif.overflow, 1'b0);

    // Read and write together while full
    drive(1, 0, 1, 0, 1, T5);
    tick("full_rw");
    check("full_rw_ovf", bif.overflow, 1'b0);
    check("full_rw_af", bif.almost_full, 1'b1);
    check("full_rw_head", bif.core_data, T4 + DW'(2));

    // Write while full with no read drops the word
    drive(1, 0, 1, 0, 0, T4 + DW'(17));
    tick("ovf");
    check("ovf_set", bif.overflow, 1'b1);

    drive(1, 0, 0, 0, 1, '0);
    drained = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.core_valid) begin
        check("drop_absent", bif.core_data == T4 + DW'(17), 1'b0);
        drained++;
        tick("drain");
      end
    end
    check("drain_cnt", drained, 16);
    check("drain_empty", bif.core_valid, 1'b0);
    check("ovf_sticky", bif.overflow, 1'b1);
    drive(0, 0, 0, 0, 0, '0);
    tick("drain_idle");

    // Write with a read request on an empty FIFO
    drive(1, 0, 1, 0, 1, T6);
    tick("empty_rw");
    check("empty_rw_valid", bif.core_valid, 1'b1);
    check("empty_rw_data", bif.core_data, T6);

    // Reset asserted mid-stream
    for (int n = 0; n < 5; n++) begin
      drive(1, 0, 1, 0, 0, T4 + DW'(32 + n));
      tick("pre_rst");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_valid", bif.core_valid, 1'b0);
    check("rst_ovf", bif.overflow, 1'b0);
    check("rst_last", bif.core_last, 1'b0);
    check("rst_af", bif.almost_full, 1'b0);
    for (int i = 0; i < NCFG; i++) check($sformatf("rst_cfg%0d", i), bif.cfg[i*DW +: DW], '0);
    model_reset();
    drive(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("post_rst");

    // Randomized traffic across phases
    r_run   = 1'b0;
    r_com   = 1'b0;
    rdy_pct = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) rdy_pct = $urandom_range(10, 100);
      if ($urandom_range(0, 15) == 0) r_run = ~r_run;
      if ($urandom_range(0, 11) == 0) r_com = ~r_com;
      v   = r_run && ($urandom_range(0, 1) == 1);
      c   = r_com && ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      d   = c ? DW'($urandom_range(0, 4)) : {$urandom, $urandom};
      drive(r_run, r_com, v, c, rdy, d);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
